// File: rtl/uart_echo_responder.sv
// rtl/uart_echo_responder.sv - far-end UART echo responder: rx edge capture, byte FIFO, tx handshake FSM
module uart_echo_responder #(
  parameter int         FIFO_DEPTH    = 8,
  parameter logic [7:0] XOR_MASK      = 8'h00,
  parameter int         BUSY_WAIT_MAX = 16,
  parameter int         CNT_W         = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_done,
  input  logic                          tx_busy,
  output logic                          tx_start,
  output logic [7:0]                    tx_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [CNT_W-1:0]              rx_count,
  output logic [CNT_W-1:0]              tx_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(BUSY_WAIT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t          state;
  logic [WW-1:0]   wait_cnt;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            rx_done_q;

  logic            push_edge;
  logic            fifo_empty;
  logic            fifo_full;
  logic            pop;
  logic            push_ok;
  logic            push_drop;

  // rx_done may be held as a level; only its rising edge counts as a byte
  assign push_edge  = rx_done & ~rx_done_q;
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
  assign pop        = (state == IDLE) & ~fifo_empty & ~tx_busy;
  assign push_ok    = push_edge & (~fifo_full | pop);
  assign push_drop  = push_edge & ~push_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_done_q  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      rx_count   <= '0;
    end else begin
      rx_done_q <= rx_done;
      if (push_ok) begin
        wr_ptr   <= wr_ptr + AW'(1);
        rx_count <= rx_count + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (push_drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset; the pointers define which entries are live
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= rx_data ^ XOR_MASK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      tx_count <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            tx_start <= 1'b1;
            tx_data  <= mem[rd_ptr];
            tx_count <= tx_count + CNT_W'(1);
            state    <= START;
          end
        end
        START: begin
          tx_start <= 1'b0;
          wait_cnt <= WW'(BUSY_WAIT_MAX);
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else begin
            // A transmitter that never goes busy forfeits the byte
            wait_cnt <= wait_cnt - WW'(1);
            if (wait_cnt <= WW'(1)) begin
              state <= IDLE;
            end
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_responder.sv
// tb/tb_uart_echo_responder.sv - randomized bench for uart_echo_responder with plain and 8'hFF-masked instances
module tb_uart_echo_responder;

  localparam int DEPTH = 8;
  localparam int BWM   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        busy0, busy1;
  logic        tx_start0, tx_start1;
  logic [7:0]  tx_data0, tx_data1;
  logic [3:0]  fifo_count0, fifo_count1;
  logic        overflow0, overflow1;
  logic [15:0] rx_count0, rx_count1, tx_count0, tx_count1;

  uart_echo_responder #(.FIFO_DEPTH(DEPTH), .XOR_MASK(8'h00), .BUSY_WAIT_MAX(BWM), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .tx_busy(busy0),
    .tx_start(tx_start0), .tx_data(tx_data0), .fifo_count(fifo_count0), .overflow(overflow0),
    .rx_count(rx_count0), .tx_count(tx_count0));

  uart_echo_responder #(.FIFO_DEPTH(DEPTH), .XOR_MASK(8'hFF), .BUSY_WAIT_MAX(BWM), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .tx_busy(busy1),
    .tx_start(tx_start1), .tx_data(tx_data1), .fifo_count(fifo_count1), .overflow(overflow1),
    .rx_count(rx_count1), .tx_count(tx_count1));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: expected echo streams, counters, sticky overflow
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int rx_model = 0, tx_model0 = 0, tx_model1 = 0;
  logic ovf_model = 1'b0;
  int cyc = 0;
  int start_cyc0[$];

  // Transmitter model: 0 = never busy, 1 = held busy, 2 = busy for a length after each start
  int   mode = 0;
  int   fixed_len = 0;
  logic rand_len = 1'b0;
  int   cnt0, cnt1;
  logic busy_prev0, busy_prev1, start_prev0, start_prev1;

  assign busy0 = (mode == 1) || (mode == 2 && cnt0 != 0);
  assign busy1 = (mode == 1) || (mode == 2 && cnt1 != 0);

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= 0; cnt1 <= 0; busy_prev0 <= 1'b0; busy_prev1 <= 1'b0;
    end else begin
      busy_prev0 <= busy0;
      busy_prev1 <= busy1;
      if (tx_start0) cnt0 <= rand_len ? int'($urandom_range(12, 0)) : fixed_len;
      else if (cnt0 > 0) cnt0 <= cnt0 - 1;
      if (tx_start1) cnt1 <= rand_len ? int'($urandom_range(12, 0)) : fixed_len;
      else if (cnt1 > 0) cnt1 <= cnt1 - 1;
    end
  end

  always @(negedge clk) begin
    start_prev0 <= tx_start0;
    start_prev1 <= tx_start1;
  end

  always @(negedge clk) begin
    if (!rst && tx_start0) begin
      check("start0_while_busy", 32'(busy_prev0), 0);
      check("start0_pulse_width", 32'(start_prev0), 0);
      start_cyc0.push_back(cyc);
      if (q0.size() == 0) check("start0_unexpected", 1, 0);
      else begin
        check("echo0_data", 32'(tx_data0), 32'(q0.pop_front()));
        tx_model0++;
      end
    end
    if (!rst && tx_start1) begin
      check("start1_while_busy", 32'(busy_prev1), 0);
      check("start1_pulse_width", 32'(start_prev1), 0);
      if (q1.size() == 0) check("start1_unexpected", 1, 0);
      else begin
        check("echo1_data", 32'(tx_data1), 32'(q1.pop_front()));
        tx_model1++;
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, input int hold, input int gap);
    rx_data = b;
    rx_done = 1'b1;
    if (q0.size() < DEPTH) begin
      q0.push_back(b);
      q1.push_back(b ^ 8'hFF);
      rx_model++;
    end else begin
      ovf_model = 1'b1;
    end
    repeat (hold) @(negedge clk);
    rx_done = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic chk_counts(input string tag);
    check({tag, "_fifo0"}, 32'(fifo_count0), 32'(q0.size()));
    check({tag, "_fifo1"}, 32'(fifo_count1), 32'(q1.size()));
    check({tag, "_rxcnt0"}, 32'(rx_count0), 32'(rx_model & 16'hFFFF));
    check({tag, "_rxcnt1"}, 32'(rx_count1), 32'(rx_model & 16'hFFFF));
    check({tag, "_txcnt0"}, 32'(tx_count0), 32'(tx_model0 & 16'hFFFF));
    check({tag, "_txcnt1"}, 32'(tx_count1), 32'(tx_model1 & 16'hFFFF));
    check({tag, "_ovf0"}, 32'(overflow0), 32'(ovf_model));
    check({tag, "_ovf1"}, 32'(overflow1), 32'(ovf_model));
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_start0"}, 32'(tx_start0), 0);
    check({tag, "_data0"}, 32'(tx_data0), 0);
    check({tag, "_start1"}, 32'(tx_start1), 0);
    check({tag, "_data1"}, 32'(tx_data1), 0);
    check({tag, "_fifo0"}, 32'(fifo_count0), 0);
    check({tag, "_fifo1"}, 32'(fifo_count1), 0);
    check({tag, "_ovf0"}, 32'(overflow0), 0);
    check({tag, "_ovf1"}, 32'(overflow1), 0);
    check({tag, "_rxcnt0"}, 32'(rx_count0), 0);
    check({tag, "_rxcnt1"}, 32'(rx_count1), 0);
    check({tag, "_txcnt0"}, 32'(tx_count0), 0);
    check({tag, "_txcnt1"}, 32'(tx_count1), 0);
  endtask

  task automatic drain(input string tag);
    int i;
    for (i = 0; i < 4000 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    if (i >= 4000) check({tag, "_drain_timeout"}, 1, 0);
    repeat (3) @(negedge clk);
    for (i = 0; i < 400 && (busy0 || busy1); i++) @(negedge clk);
    if (i >= 400) check({tag, "_busy_timeout"}, 1, 0);
    repeat (BWM + 4) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single byte: start pulse lands on the 2nd edge after capture
    mode = 2; fixed_len = 100; rand_len = 1'b0;
    rx_data = 8'hA5; rx_done = 1'b1;
    q0.push_back(8'hA5); q1.push_back(8'h5A); rx_model++;
    @(negedge clk);
    check("lat_k_start", 32'(tx_start0), 0);
    check("lat_k_fifo", 32'(fifo_count0), 1);
    rx_done = 1'b0;
    @(negedge clk);
    check("lat_k1_start", 32'(tx_start0), 1);
    check("lat_k1_data", 32'(tx_data0), 32'hA5);
    check("lat_k1_data_mask", 32'(tx_data1), 32'h5A);
    check("lat_k1_fifo", 32'(fifo_count0), 0);
    @(negedge clk);
    check("lat_k2_start", 32'(tx_start0), 0);
    drain("single");
    chk_counts("single");

    // Burst while the transmitter is held busy, then released
    mode = 1;
    foreach (start_cyc0[i]) start_cyc0.delete(i);
    begin
      logic [7:0] burst [5];
      burst = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h55};
      for (int i = 0; i < 5; i++) push_byte(burst[i], 1, 2);
    end
    @(negedge clk);
    chk_counts("burst_held");
    mode = 2; fixed_len = 7;
    drain("burst");
    chk_counts("burst");

    // Overflow: ten pushes into an eight-entry buffer
    mode = 1;
    for (int i = 0; i < 10; i++) push_byte(8'($urandom), 1, 1);
    @(negedge clk);
    check("ovf_fifo_full", 32'(fifo_count0), DEPTH);
    chk_counts("ovf_held");
    mode = 2; fixed_len = 3;
    drain("ovf");
    chk_counts("ovf_drained");

    // Level rx_done: one echo for a 20-cycle high period
    mode = 2; fixed_len = 5;
    push_byte(8'h3C, 20, 2);
    drain("level");
    chk_counts("level");

    // Random traffic with random pulse widths, gaps and busy lengths
    rand_len = 1'b1;
    for (int n = 0; n < 40; n++) begin
      for (int w = 0; w < 500 && (q0.size() >= DEPTH - 1 || q1.size() >= DEPTH - 1); w++)
        @(negedge clk);
      push_byte(8'($urandom), int'($urandom_range(4, 1)), int'($urandom_range(5, 1)));
    end
    drain("random");
    chk_counts("random");
    rand_len = 1'b0;

    // Busy never rises: each start waits out the full timeout
    mode = 0;
    start_cyc0.delete();
    push_byte(8'h11, 1, 1);
    push_byte(8'h22, 1, 1);
    drain("timeout");
    chk_counts("timeout");
    if (start_cyc0.size() == 2)
      check("timeout_spacing", 32'(start_cyc0[1] - start_cyc0[0]), BWM + 2);
    else
      check("timeout_start_count", 32'(start_cyc0.size()), 2);

    // Asynchronous reset while waiting for busy to fall with 3 bytes queued
    mode = 1;
    for (int i = 0; i < 4; i++) push_byte(8'($urandom), 1, 1);
    mode = 2; fixed_len = 50;
    repeat (8) @(negedge clk);
    check("pre_rst_fifo", 32'(fifo_count0), 3);
    check("pre_rst_busy", 32'(busy0), 1);
    #2 rst = 1'b1;
    #1 chk_reset("async_rst");
    q0.delete(); q1.delete();
    rx_model = 0; tx_model0 = 0; tx_model1 = 0; ovf_model = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk_counts("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
